// File: rtl/ds2_responder.sv
// DualShock 2 pad-side responder: answers the host poll on the ATT/CMD/CLK/DAT/ACK bus.
// Define DS2_RESP_ANALOG_EN for the 9-byte analog reply (ID 0x73); default is the 5-byte digital reply.
module ds2_responder #(
    parameter int ACK_DELAY = 8,
    parameter int ACK_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        ds2_att,
    input  logic        ds2_clk,
    input  logic        ds2_cmd,
    output logic        ds2_dat,
    output logic        ds2_ack,
    input  logic [15:0] buttons,
    input  logic [31:0] stick,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic        frame_done
);
`ifdef DS2_RESP_ANALOG_EN
    localparam logic [7:0] ID_BYTE  = 8'h73;
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [7:0] ID_BYTE  = 8'h41;
    localparam logic [3:0] LAST_IDX = 4'd4;
`endif
    localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK, DONE, IGNORE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [3:0]         byte_idx_q, byte_idx_d;
    logic               dat_q, dat_d, ack_q, ack_d;
    logic [7:0]         cmd_byte_q, cmd_byte_d;
    logic               cmd_valid_q, cmd_valid_d, frame_done_q, frame_done_d;
    logic [7:0]         tx_q, tx_d, rx_q, rx_d, rx_next, reply;
    logic [15:0]        btn_q, btn_d;
    logic [3:0]         idx_next;
`ifdef DS2_RESP_ANALOG_EN
    logic [31:0]        stick_q, stick_d;
`else
    logic               unused_stick;
    assign unused_stick = ^stick;
`endif

    // Stage p0/p1: two-flop synchronisers; p2 holds the previous synchronised value for edge detect
    logic att_p0, att_p1, att_p2, clk_p0, clk_p1, clk_p2, cmd_p0, cmd_p1;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            {att_p0, att_p1, att_p2} <= 3'b111;
            {clk_p0, clk_p1, clk_p2} <= 3'b111;
            {cmd_p0, cmd_p1}         <= 2'b11;
        end else begin
            {att_p0, att_p1, att_p2} <= {ds2_att, att_p0, att_p1};
            {clk_p0, clk_p1, clk_p2} <= {ds2_clk, clk_p0, clk_p1};
            {cmd_p0, cmd_p1}         <= {ds2_cmd, cmd_p0};
        end
    end

    logic att_fall, att_rise, clk_fall, clk_rise;
    assign att_fall = att_p2 & ~att_p1;
    assign att_rise = ~att_p2 & att_p1;
    assign clk_fall = clk_p2 & ~clk_p1;
    assign clk_rise = ~clk_p2 & clk_p1;
    assign rx_next  = {cmd_p1, rx_q[7:1]};
    assign idx_next = (byte_idx_q == LAST_IDX) ? byte_idx_q : byte_idx_q + 4'd1;

    always_comb begin
        reply = 8'hFF;
        case (idx_next)
            4'd1:    reply = ID_BYTE;
            4'd2:    reply = 8'h5A;
            4'd3:    reply = ~btn_q[7:0];
            4'd4:    reply = ~btn_q[15:8];
`ifdef DS2_RESP_ANALOG_EN
            4'd5:    reply = stick_q[7:0];
            4'd6:    reply = stick_q[15:8];
            4'd7:    reply = stick_q[23:16];
            4'd8:    reply = stick_q[31:24];
`endif
            default: reply = 8'hFF;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        byte_idx_d   = byte_idx_q;
        dat_d        = dat_q;
        ack_d        = 1'b1;
        cmd_byte_d   = cmd_byte_q;
        cmd_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        tx_d         = tx_q;
        rx_d         = rx_q;
        btn_d        = btn_q;
`ifdef DS2_RESP_ANALOG_EN
        stick_d      = stick_q;
`endif
        case (state_q)
            IDLE: begin
                dat_d = 1'b1;
                if (att_fall) begin
                    tx_d       = 8'hFF;
                    btn_d      = buttons;
`ifdef DS2_RESP_ANALOG_EN
                    stick_d    = stick;
`endif
                    byte_idx_d = 4'd0;
                    bit_cnt_d  = 3'd0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (att_rise) begin
                    dat_d   = 1'b1;
                    state_d = IDLE;
                end else if (clk_fall) begin
                    dat_d = tx_q[0];
                end else if (clk_rise) begin
                    rx_d      = rx_next;
                    tx_d      = tx_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        cmd_byte_d  = rx_next;
                        cmd_valid_d = 1'b1;
                        dat_d       = 1'b1;
                        cnt_d       = '0;
                        // Only the address byte can reject a frame
                        if (byte_idx_q == 4'd0 && rx_next != 8'h01) state_d = IGNORE;
                        else if (byte_idx_q == LAST_IDX)            state_d = DONE;
                        else                                        state_d = ACK_WAIT;
                    end
                end
            end
            ACK_WAIT: begin
                if (att_rise) begin
                    dat_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(ACK_DELAY - 1)) begin
                    tx_d       = reply;
                    byte_idx_d = idx_next;
                    cnt_d      = '0;
                    state_d    = ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK: begin
                if (att_rise) begin
                    dat_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    ack_d = 1'b0;
                    if (cnt_q == CNT_W'(ACK_WIDTH - 1)) state_d = SHIFT;
                    else                                cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (att_rise) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            IGNORE: begin
                dat_d = 1'b1;
                if (att_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= 3'd0;
            byte_idx_q   <= 4'd0;
            dat_q        <= 1'b1;
            ack_q        <= 1'b1;
            cmd_byte_q   <= 8'h00;
            cmd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            dat_q        <= dat_d;
            ack_q        <= ack_d;
            cmd_byte_q   <= cmd_byte_d;
            cmd_valid_q  <= cmd_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_q    <= tx_d;
        rx_q    <= rx_d;
        btn_q   <= btn_d;
`ifdef DS2_RESP_ANALOG_EN
        stick_q <= stick_d;
`endif
    end

    assign ds2_dat    = dat_q;
    assign ds2_ack    = ack_q;
    assign cmd_byte   = cmd_byte_q;
    assign cmd_valid  = cmd_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_ds2_responder.sv
// Self-checking bench for ds2_responder: host-side bus driver plus a frame-level reference model.
module tb_ds2_responder;
`ifdef DS2_RESP_ANALOG_EN
    localparam int         NB = 9;
    localparam logic [7:0] ID = 8'h73;
`else
    localparam int         NB = 5;
    localparam logic [7:0] ID = 8'h41;
`endif
    localparam int HP = 6;
    localparam int AD = 8;
    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        ds2_att = 1'b1, ds2_clk = 1'b1, ds2_cmd = 1'b1;
    logic        ds2_dat, ds2_ack;
    logic [15:0] buttons = 16'h0000;
    logic [31:0] stick = 32'h8080_8080;
    logic [7:0]  cmd_byte;
    logic        cmd_valid, frame_done;

    int checks = 0;
    int failures = 0;

    logic [7:0] cv_q[$];
    int         ack_w[$];
    int         fd_cnt = 0;
    int         ack_run = 0;
    logic [7:0] cmd_tx[NB];

    ds2_responder #(.ACK_DELAY(AD), .ACK_WIDTH(AW)) dut (
        .clk(clk), .rst_b(rst_b), .ds2_att(ds2_att), .ds2_clk(ds2_clk), .ds2_cmd(ds2_cmd),
        .ds2_dat(ds2_dat), .ds2_ack(ds2_ack), .buttons(buttons), .stick(stick),
        .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Strobe and ACK-pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) cv_q.push_back(cmd_byte);
        if (frame_done === 1'b1) fd_cnt++;
        if (ds2_ack === 1'b0) ack_run++;
        else if (ack_run != 0) begin
            ack_w.push_back(ack_run);
            ack_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pad reply as the protocol defines it, indexed by byte position
    function automatic logic [7:0] model_byte(input int i, input logic [15:0] b, input logic [31:0] s);
        logic [7:0] r[9];
        r = '{8'hFF, ID, 8'h5A, ~b[7:0], ~b[15:8], s[7:0], s[15:8], s[23:16], s[31:24]};
        return r[i];
    endfunction

    // mode 0: no ACK expected, 1: wait for full ACK pulse, 2: return once ACK goes low
    task automatic xfer(input logic [7:0] c, input int mode, output logic [7:0] d,
                        output int cvl, output int akl);
        d = 8'h00;
        cvl = -1;
        akl = -1;
        for (int b = 0; b < 8; b++) begin
            ds2_clk = 1'b0;
            ds2_cmd = c[b];
            step(HP);
            ds2_clk = 1'b1;
            d[b] = ds2_dat;
            if (b < 7) step(HP);
        end
        for (int k = 1; k <= 60; k++) begin
            step(1);
            if (cmd_valid === 1'b1 && cvl < 0) cvl = k;
            if (ds2_ack === 1'b0 && akl < 0) begin
                akl = k;
                if (mode == 2) break;
            end
            if (akl >= 0 && ds2_ack === 1'b1) break;
            if (mode == 0 && k >= 30) break;
        end
        ds2_cmd = 1'b1;
    endtask

    task automatic poll(input int chg_byte, input logic [15:0] chg_btn);
        logic [15:0] lat_b;
        logic [31:0] lat_s;
        logic [7:0]  got;
        logic        acc;
        int          cvl, akl;
        lat_b = buttons;
        lat_s = stick;
        acc   = (cmd_tx[0] == 8'h01);
        cv_q.delete();
        ack_w.delete();
        fd_cnt = 0;
        ds2_att = 1'b0;
        step(HP);
        for (int i = 0; i < NB; i++) begin
            if (i == chg_byte) buttons = chg_btn;
            xfer(cmd_tx[i], (acc && i < NB - 1) ? 1 : 0, got, cvl, akl);
            chk($sformatf("dat_byte%0d", i), 32'(got),
                32'((i == 0 || acc) ? model_byte(i, lat_b, lat_s) : 8'hFF));
            if (i == 0 || acc) chk($sformatf("cv_latency%0d", i), 32'(cvl), 32'd3);
            chk($sformatf("ack_latency%0d", i), 32'(akl), (acc && i < NB - 1) ? 32'(3 + AD + 1) : 32'hFFFF_FFFF);
            step(HP);
        end
        ds2_att = 1'b1;
        step(8);
        chk("cmd_valid_count", 32'(cv_q.size()), acc ? 32'(NB) : 32'd1);
        for (int i = 0; i < cv_q.size() && i < NB; i++)
            chk($sformatf("cmd_byte%0d", i), 32'(cv_q[i]), 32'(cmd_tx[i]));
        chk("ack_count", 32'(ack_w.size()), acc ? 32'(NB - 1) : 32'd0);
        for (int i = 0; i < ack_w.size(); i++)
            chk($sformatf("ack_width%0d", i), 32'(ack_w[i]), 32'(AW));
        chk("frame_done_count", 32'(fd_cnt), acc ? 32'd1 : 32'd0);
        step(HP);
    endtask

    initial begin
        logic [7:0] got;
        int         cvl, akl;

        step(3);
        rst_b = 1'b1;
        step(2);
        chk("reset_dat", 32'(ds2_dat), 32'd1);
        chk("reset_ack", 32'(ds2_ack), 32'd1);
        chk("reset_cmd_byte", 32'(cmd_byte), 32'h00);
        chk("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);

        // Directed digital poll with UP pressed
        buttons = 16'h0010;
        stick   = 32'h1020_3040;
        for (int i = 0; i < NB; i++) cmd_tx[i] = (i == 0) ? 8'h01 : ((i == 1) ? 8'h42 : 8'h00);
        poll(-1, 16'h0000);

        // Wrong address
        cmd_tx[0] = 8'h81;
        poll(-1, 16'h0000);
        cmd_tx[0] = 8'h01;

        // Abort three bits into byte 2
        cv_q.delete();
        fd_cnt = 0;
        ds2_att = 1'b0;
        step(HP);
        xfer(8'h01, 1, got, cvl, akl);
        step(HP);
        xfer(8'h42, 1, got, cvl, akl);
        step(HP);
        for (int b = 0; b < 3; b++) begin
            ds2_clk = 1'b0;
            step(HP);
            ds2_clk = 1'b1;
            step(HP);
        end
        chk("abort_dat_before", 32'(ds2_dat), 32'd0);
        ds2_att = 1'b1;
        step(3);
        chk("abort_dat", 32'(ds2_dat), 32'd1);
        chk("abort_ack", 32'(ds2_ack), 32'd1);
        step(12);
        chk("abort_frame_done", 32'(fd_cnt), 32'd0);
        chk("abort_cmd_valid", 32'(cv_q.size()), 32'd2);
        poll(-1, 16'h0000);

        // Buttons latched at ATT fall
        buttons = 16'h0000;
        poll(1, 16'hFFFF);
        poll(-1, 16'h0000);

        // Randomized frames
        for (int f = 0; f < 5; f++) begin
            buttons = 16'($urandom);
            stick   = $urandom;
            for (int i = 0; i < NB; i++) cmd_tx[i] = 8'($urandom);
            cmd_tx[0] = (f == 4) ? 8'($urandom_range(2, 255)) : 8'h01;
            poll(-1, 16'h0000);
        end

        // Reset while ACK is low
        cmd_tx[0] = 8'h01;
        ds2_att = 1'b0;
        step(HP);
        xfer(8'h01, 2, got, cvl, akl);
        chk("rst_pre_ack", 32'(ds2_ack), 32'd0);
        #2 rst_b = 1'b0;
        #1;
        chk("rst_async_ack", 32'(ds2_ack), 32'd1);
        chk("rst_async_dat", 32'(ds2_dat), 32'd1);
        chk("rst_cmd_byte", 32'(cmd_byte), 32'h00);
        ds2_att = 1'b1;
        ds2_clk = 1'b1;
        step(3);
        cv_q.delete();
        ack_w.delete();
        fd_cnt = 0;
        rst_b = 1'b1;
        step(30);
        chk("rst_no_cmd_valid", 32'(cv_q.size()), 32'd0);
        chk("rst_no_frame_done", 32'(fd_cnt), 32'd0);
        chk("rst_no_ack", 32'(ack_w.size()), 32'd0);
        buttons = 16'h8001;
        poll(-1, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
